// File: rtl/sdram_read_arbiter.sv
// sdram_read_arbiter: shares one Avalon-MM burst-read SDRAM port between
// two read masters and routes each returned beat to the burst's owner.
module sdram_read_arbiter #(
    parameter int ADDRESS_WIDTH   = 29,
    parameter int DATA_WIDTH      = 64,
    parameter int BURST_WIDTH     = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [ADDRESS_WIDTH-1:0]         m0_address,
    input  logic [BURST_WIDTH-1:0]           m0_burstcount,
    input  logic                             m0_read,
    output logic                             m0_waitrequest,
    output logic [DATA_WIDTH-1:0]            m0_readdata,
    output logic                             m0_readdatavalid,
    input  logic [ADDRESS_WIDTH-1:0]         m1_address,
    input  logic [BURST_WIDTH-1:0]           m1_burstcount,
    input  logic                             m1_read,
    output logic                             m1_waitrequest,
    output logic [DATA_WIDTH-1:0]            m1_readdata,
    output logic                             m1_readdatavalid,
    output logic [ADDRESS_WIDTH-1:0]         s_address,
    output logic [BURST_WIDTH-1:0]           s_burstcount,
    output logic                             s_read,
    input  logic                             s_waitrequest,
    input  logic [DATA_WIDTH-1:0]            s_readdata,
    input  logic                             s_readdatavalid,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                             error
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [BURST_WIDTH-1:0]   bc_q, bc_d;
    logic                     read_q, read_d;
    logic                     gid_q, gid_d;
    logic [SW-1:0]            starve_q, starve_d;

    logic                     tag_id_q [MAX_OUTSTANDING];
    logic [BURST_WIDTH-1:0]   tag_bc_q [MAX_OUTSTANDING];
    logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [PW:0]              cnt_q;
    logic [BURST_WIDTH-1:0]   beat_q, beat_d;
    logic                     busy_q;
    logic                     error_q;

    logic                     full, empty, accept, beat, last, pop;
    logic                     head_id, pick1;
    logic [BURST_WIDTH-1:0]   head_bc, sel_bc;

    assign full    = (cnt_q == (PW+1)'(MAX_OUTSTANDING));
    assign empty   = (cnt_q == '0);
    assign accept  = (state_q == ISSUE) && !s_waitrequest;
    assign head_id = tag_id_q[rd_ptr_q];
    assign head_bc = tag_bc_q[rd_ptr_q];
    assign beat    = s_readdatavalid && !empty;
    assign beat_d  = busy_q ? (beat_q - 1'b1) : (head_bc - 1'b1);
    assign last    = (beat_d == '0);
    assign pop     = beat && last;

    assign s_address        = addr_q;
    assign s_burstcount     = bc_q;
    assign s_read           = read_q;
    assign m0_waitrequest   = !(accept && !gid_q);
    assign m1_waitrequest   = !(accept && gid_q);
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = beat && !head_id;
    assign m1_readdatavalid = beat && head_id;
    assign outstanding      = cnt_q;
    assign error            = error_q;

    // Arbitration and command issue: pick a winner in IDLE, hold it until accepted.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        bc_d     = bc_q;
        read_d   = read_q;
        gid_d    = gid_q;
        starve_d = m1_read ? starve_q : '0;
        pick1    = !m0_read || (starve_q == SW'(STARVE_LIMIT));
        sel_bc   = pick1 ? m1_burstcount : m0_burstcount;
        unique case (state_q)
            IDLE: begin
                if ((m0_read || m1_read) && !full) begin
                    addr_d  = pick1 ? m1_address : m0_address;
                    bc_d    = (sel_bc == '0) ? BURST_WIDTH'(1) : sel_bc;
                    read_d  = 1'b1;
                    gid_d   = pick1;
                    state_d = ISSUE;
                    if (pick1)
                        starve_d = '0;
                    else if (m1_read)
                        starve_d = starve_q + 1'b1;
                end
            end
            ISSUE: begin
                if (!s_waitrequest) begin
                    read_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command-side registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            bc_q     <= '0;
            read_q   <= 1'b0;
            gid_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            bc_q     <= bc_d;
            read_q   <= read_d;
            gid_q    <= gid_d;
            starve_q <= starve_d;
        end
    end

    // Tag storage: owner and length of each accepted burst, written at the tail.
    always_ff @(posedge clock) begin
        if (accept) begin
            tag_id_q[wr_ptr_q] <= gid_q;
            tag_bc_q[wr_ptr_q] <= bc_q;
        end
    end

    // Tag FIFO pointers, occupancy, beat counter and sticky stray-beat flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            beat_q   <= '0;
            busy_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            if (accept)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            if (accept && !pop)
                cnt_q <= cnt_q + (PW+1)'(1);
            else if (!accept && pop)
                cnt_q <= cnt_q - (PW+1)'(1);
            if (beat) begin
                beat_q <= beat_d;
                busy_q <= !last;
            end
            if (s_readdatavalid && empty)
                error_q <= 1'b1;
        end
    end

endmodule
